mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Sequences and shares one single-port memory between two requesters:
  - the instruction-fetch path (read only);
  - the load/store data path (read/write).
- Lets instruction and data memory be merged into one unified memory behind the MIPS datapath.
- Grants one access at a time, drives the memory port for a fixed read latency and returns the result with a one-cycle ready pulse.
- Data accesses have priority; a consecutive-grant limit keeps fetch from starving.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 1, memory read latency in cycles after the mem_en cycle; legal range 1..15
- MAX_CONSEC, 4, maximum consecutive contested data grants before fetch is forced; legal range 1..15

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_ready  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; level, held until d_ready
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  one-cycle pulse; access complete
- d_rdata  out  DATA_W  read data; 0 for writes
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the mem_en cycle
- busy  out  1  high in every state except IDLE
- owner  out  1  0 = fetch, 1 = data; holds the last granted requester

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant data if consec < MAX_CONSEC, else grant fetch.
  - On a grant: latch owner, address, we and wdata, then go to ISSUE.
- consec counter (4 bits):
  - Increments on each contested data grant, saturating at 15.
  - Clears to 0 on any fetch grant.
  - Unchanged on an uncontested data grant.
- ISSUE:
  - mem_en = 1, mem_we = latched we (0 for fetch); mem_addr and mem_wdata are the latched values.
  - Load the latency counter with LATENCY and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter reaches 1, capture mem_rdata into the owner's rdata register (write captures 0), then go to DONE.
- DONE:
  - Pulse the owner's ready for one cycle; the other ready stays 0. Next state is IDLE.
- mem_addr and mem_wdata hold their last values outside ISSUE. mem_we is 0 whenever mem_en is 0.
- Requesters deassert req, or present a new request, in the cycle after ready. Req is never sampled in ISSUE, WAIT or DONE.
- A request dropped before its ready pulse is a protocol violation; the access still completes and ready still pulses.
- if_rdata and d_rdata hold their values until the next completion for the same requester.

## Timing
- Request seen in IDLE at cycle 0. The ISSUE state, and therefore the mem_en cycle, is cycle 1 (mem_en drives there). mem_rdata is sampled at the end of cycle 1+LATENCY. The ready pulse is in cycle 2+LATENCY.
- Per-access occupancy is LATENCY+3 cycles. Back-to-back accesses: the next grant is decided in the IDLE cycle after DONE.
- Reset values: state IDLE, all outputs 0, consec 0, latency counter 0.
- Reset asserted mid-access (ISSUE/WAIT/DONE):
  - Outputs clear immediately (asynchronously), including mem_en.
  - The access is abandoned; no ready pulse occurs.
  - After reset deasserts, still-held requests are re-arbitrated from IDLE.

## Test plan
- Fetch alone, LATENCY=1:
  - Stimulus: if_addr=0x00000004, memory returns 0x8C220000.
  - Required: mem_en=1, mem_we=0, mem_addr=0x00000004 in cycle 1; if_ready=1 with if_rdata=0x8C220000 in cycle 3; d_ready=0 throughout.
- Data write then read-back:
  - Stimulus: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, then d_we=0, d_addr=0x10.
  - Required: write has mem_we=1 for exactly 1 cycle and d_rdata=0 at its d_ready; read returns d_rdata=0xDEADBEEF.
- Contention, MAX_CONSEC=4:
  - Stimulus: if_req and d_req both held continuously, each re-requesting after ready.
  - Required: grant order D,D,D,D,IF,D,D,D,D,IF; owner matches each grant.
- Simultaneous request from IDLE with consec=0:
  - Required: data granted first, fetch granted in the next IDLE; consec=0 after the fetch grant.
- LATENCY=3, single fetch:
  - Required: mem_en in cycle 1, rdata sampled at end of cycle 4, if_ready in cycle 5; busy high in cycles 1-5.
- Reset pulse in WAIT of a data read (LATENCY=3):
  - Required: mem_en, busy and d_ready are 0 immediately; no d_ready pulse afterwards; held d_req is re-granted with mem_en in the 2nd cycle after reset release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store paths.
// Data accesses win contention until a consecutive-grant limit forces a fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    stateT             state, stateNext;
    logic [3:0]        consec, consecNext;
    logic [3:0]        latCnt, latCntNext;
    logic              opWe, opWeNext;
    logic              ownerNext;
    logic              memEnNext, memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic              ifReadyNext, dReadyNext;
    logic [DATA_W-1:0] ifRdataNext, dRdataNext;
    logic              busyNext;

    logic contested;
    logic grantData;

    assign contested = if_req && d_req;
    assign grantData = d_req && (!if_req || (consec < 4'(MAX_CONSEC)));

    // State register; every output is a flop so the memory port and ready pulses are glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            consec    <= '0;
            latCnt    <= '0;
            opWe      <= 1'b0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            consec    <= consecNext;
            latCnt    <= latCntNext;
            opWe      <= opWeNext;
            owner     <= ownerNext;
            mem_en    <= memEnNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            if_ready  <= ifReadyNext;
            d_ready   <= dReadyNext;
            if_rdata  <= ifRdataNext;
            d_rdata   <= dRdataNext;
            busy      <= busyNext;
        end
    end

    // Next-state logic computes the value each output takes in the following state,
    // so the strobe appears in ISSUE and the ready pulse appears in DONE.
    always_comb begin
        stateNext    = state;
        consecNext   = consec;
        latCntNext   = latCnt;
        opWeNext     = opWe;
        ownerNext    = owner;
        memEnNext    = 1'b0;
        memWeNext    = 1'b0;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        ifReadyNext  = 1'b0;
        dReadyNext   = 1'b0;
        ifRdataNext  = if_rdata;
        dRdataNext   = d_rdata;

        case (state)
            IDLE: begin
                if (grantData) begin
                    stateNext    = ISSUE;
                    ownerNext    = 1'b1;
                    opWeNext     = d_we;
                    memEnNext    = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    if (contested && (consec != 4'd15)) begin
                        consecNext = consec + 4'd1;
                    end
                end else if (if_req) begin
                    stateNext   = ISSUE;
                    ownerNext   = 1'b0;
                    opWeNext    = 1'b0;
                    memEnNext   = 1'b1;
                    memAddrNext = if_addr;
                    consecNext  = '0;
                end
            end
            ISSUE: begin
                latCntNext = 4'(LATENCY);
                stateNext  = WAIT;
            end
            WAIT: begin
                latCntNext = latCnt - 4'd1;
                // The final WAIT cycle lines up with the memory's read-data window.
                if (latCnt == 4'd1) begin
                    stateNext = DONE;
                    if (owner) begin
                        dReadyNext = 1'b1;
                        dRdataNext = opWe ? '0 : mem_rdata;
                    end else begin
                        ifReadyNext = 1'b1;
                        ifRdataNext = mem_rdata;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester expected-data queues, a grant-order
// queue from an arbitration model, and a memory responder that only drives valid data in its window.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int MAXC = 4;

    logic          clock;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    int passedChecks = 0;
    int totalChecks  = 0;
    int weCycles     = 0;
    int weWithoutEn  = 0;
    int consecModel  = 0;

    logic [31:0] ifExpQ[$];
    logic [31:0] dExpQ[$];
    logic        orderQ[$];
    logic [31:0] slaveMem[logic [31:0]];
    logic [31:0] refMem[logic [31:0]];

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .MAX_CONSEC(MAXC)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return (a == 32'h4) ? 32'h8C22_0000 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) passedChecks++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    // Arbitration model: both requesters keep a request pending until their count runs out.
    task automatic modelOrder(input int nFetch, input int nData);
        while (nFetch > 0 || nData > 0) begin
            if (nFetch > 0 && nData > 0) begin
                if (consecModel < MAXC) begin
                    orderQ.push_back(1'b1);
                    nData--;
                    if (consecModel < 15) consecModel++;
                end else begin
                    orderQ.push_back(1'b0);
                    nFetch--;
                    consecModel = 0;
                end
            end else if (nData > 0) begin
                orderQ.push_back(1'b1);
                nData--;
            end else begin
                orderQ.push_back(1'b0);
                nFetch--;
                consecModel = 0;
            end
        end
    endtask

    // Memory responder: mem_rdata is valid only in the LAT-th cycle after the mem_en cycle.
    initial begin
        logic [31:0] rdVal;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            if (mem_en === 1'b1) begin
                if (mem_we === 1'b1) begin
                    slaveMem[mem_addr] = mem_wdata;
                end else begin
                    rdVal = slaveMem.exists(mem_addr) ? slaveMem[mem_addr] : initWord(mem_addr);
                    for (int k = 1; k < LAT; k++) @(posedge clock);
                    #1 mem_rdata = rdVal;
                    @(posedge clock);
                    #1 mem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a ready pulse is presented.
    always @(negedge clock) begin
        if (mem_we === 1'b1) weCycles++;
        if (mem_we === 1'b1 && mem_en !== 1'b1) weWithoutEn++;
        if (!reset) begin
            if (if_ready === 1'b1 || d_ready === 1'b1)
                checkOutput("readyExclusive", {31'b0, if_ready & d_ready}, 32'h0);
            if (if_ready === 1'b1) begin
                checkOutput("ifOwner", {31'b0, owner}, 32'h0);
                if (orderQ.size() > 0) checkOutput("grantOrder", 32'h0, {31'b0, orderQ.pop_front()});
                if (ifExpQ.size() == 0) checkOutput("ifUnexpectedReady", 32'h1, 32'h0);
                else checkOutput("if_rdata", if_rdata, ifExpQ.pop_front());
            end
            if (d_ready === 1'b1) begin
                checkOutput("dOwner", {31'b0, owner}, 32'h1);
                if (orderQ.size() > 0) checkOutput("grantOrder", 32'h1, {31'b0, orderQ.pop_front()});
                if (dExpQ.size() == 0) checkOutput("dUnexpectedReady", 32'h1, 32'h0);
                else checkOutput("d_rdata", d_rdata, dExpQ.pop_front());
            end
        end
    end

    task automatic fetchRequest(input logic [31:0] a);
        bit seen = 0;
        if_addr = a;
        if_req  = 1'b1;
        ifExpQ.push_back(initWord(a));
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clock);
            if (if_ready === 1'b1) seen = 1;
        end
        if (!seen) checkOutput("ifReadyTimeout", 32'h0, 32'h1);
        @(posedge clock);
        #1 if_req = 1'b0;
    endtask

    task automatic dataRequest(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bit seen = 0;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        if (we) begin
            refMem[a] = wd;
            dExpQ.push_back(32'h0);
        end else begin
            dExpQ.push_back(refMem.exists(a) ? refMem[a] : initWord(a));
        end
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clock);
            if (d_ready === 1'b1) seen = 1;
        end
        if (!seen) checkOutput("dReadyTimeout", 32'h0, 32'h1);
        @(posedge clock);
        #1 d_req = 1'b0;
    endtask

    // Random traffic from both requesters with random idle gaps.
    task automatic applyStimulus(input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                    fetchRequest(32'h100 + 4 * $urandom_range(0, 63));
                end
            end
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                    dataRequest(1'($urandom_range(0, 1)), 32'h1000 + 4 * $urandom_range(0, 7), $urandom);
                end
            end
        join
    endtask

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(negedge clock);
        checkOutput("rstMemEn", {31'b0, mem_en}, 32'h0);
        checkOutput("rstBusy", {31'b0, busy}, 32'h0);
        checkOutput("rstOwner", {31'b0, owner}, 32'h0);
        checkOutput("rstReady", {30'b0, if_ready, d_ready}, 32'h0);
        checkOutput("rstIfRdata", if_rdata, 32'h0);
        checkOutput("rstDRdata", d_rdata, 32'h0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Fetch alone with cycle-exact checks of the port timing.
        #1;
        if_addr = 32'h4;
        if_req  = 1'b1;
        ifExpQ.push_back(32'h8C22_0000);
        @(posedge clock); #1;
        checkOutput("c1MemEn", {31'b0, mem_en}, 32'h1);
        checkOutput("c1MemWe", {31'b0, mem_we}, 32'h0);
        checkOutput("c1MemAddr", mem_addr, 32'h4);
        checkOutput("c1Busy", {31'b0, busy}, 32'h1);
        for (int c = 2; c <= 1 + LAT; c++) begin
            @(posedge clock); #1;
            checkOutput("waitMemEn", {31'b0, mem_en}, 32'h0);
            checkOutput("waitIfReady", {31'b0, if_ready}, 32'h0);
            checkOutput("waitBusy", {31'b0, busy}, 32'h1);
        end
        @(posedge clock); #1;
        checkOutput("doneIfReady", {31'b0, if_ready}, 32'h1);
        checkOutput("doneDReady", {31'b0, d_ready}, 32'h0);
        checkOutput("doneBusy", {31'b0, busy}, 32'h1);
        @(posedge clock); #1;
        if_req = 1'b0;
        checkOutput("afterIfReady", {31'b0, if_ready}, 32'h0);
        checkOutput("afterBusy", {31'b0, busy}, 32'h0);
        consecModel = 0;

        // Write then read-back of the same data address.
        @(posedge clock); #1;
        weCycles = 0;
        dataRequest(1'b1, 32'h10, 32'hDEAD_BEEF);
        checkOutput("writeWeCycles", weCycles, 32'h1);
        dataRequest(1'b0, 32'h10, 32'h0);

        // Simultaneous request from IDLE, then sustained contention.
        modelOrder(1, 1);
        fork
            fetchRequest(32'h180);
            dataRequest(1'b0, 32'h10, 32'h0);
        join
        modelOrder(2, 8);
        fork
            begin
                for (int i = 0; i < 2; i++) fetchRequest(32'h104 + 4 * i);
            end
            begin
                for (int i = 0; i < 8; i++) dataRequest(1'(i % 2), 32'h1000 + 4 * (i % 4), 32'hC0DE_0000 + i);
            end
        join
        checkOutput("orderQueueDrained", orderQ.size(), 32'h0);

        // Reset in WAIT of a data read; the held request must be re-arbitrated.
        @(posedge clock); #1;
        d_we   = 1'b0;
        d_addr = 32'h1004;
        d_req  = 1'b1;
        dExpQ.push_back(refMem.exists(32'h1004) ? refMem[32'h1004] : initWord(32'h1004));
        @(posedge clock); #1;
        checkOutput("rstTestIssue", {31'b0, mem_en}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midRstMemEn", {31'b0, mem_en}, 32'h0);
        checkOutput("midRstBusy", {31'b0, busy}, 32'h0);
        checkOutput("midRstDReady", {31'b0, d_ready}, 32'h0);
        repeat (4) begin
            @(negedge clock);
            checkOutput("rstHoldDReady", {31'b0, d_ready}, 32'h0);
        end
        reset = 1'b0;
        consecModel = 0;
        #1 checkOutput("relMemEn", {31'b0, mem_en}, 32'h0);
        @(posedge clock); #1;
        checkOutput("regrantMemEn", {31'b0, mem_en}, 32'h1);
        checkOutput("regrantAddr", mem_addr, 32'h1004);
        begin
            bit seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clock);
                if (d_ready === 1'b1) seen = 1;
            end
            if (!seen) checkOutput("regrantTimeout", 32'h0, 32'h1);
        end
        @(posedge clock); #1;
        d_req = 1'b0;

        @(posedge clock); #1;
        applyStimulus(20);

        repeat (4) @(posedge clock);
        checkOutput("memWeWithoutEn", weWithoutEn, 32'h0);
        checkOutput("ifQueueEmpty", ifExpQ.size(), 32'h0);
        checkOutput("dQueueEmpty", dExpQ.size(), 32'h0);
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
